// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
//
// Shared definitions for the 16:1 mux scan sequencer:
//   CHAN_N        number of mux channels
//   SEL_W         width of the mux select
//   state_e       sequencer states (IDLE, SCAN, DONE)
//   next_bit_t    result of the channel search (found flag + channel index)
//   next_set_bit  lowest set mask bit strictly above a signed start index;
//                 an index of -1 searches the whole mask
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int CHAN_N = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } next_bit_t;

    // Walk from the top channel down so the last hit is the lowest
    // qualifying bit, giving a plain priority encoder after synthesis.
    function automatic next_bit_t next_set_bit(
        input logic        [CHAN_N-1:0] mask,
        input logic signed [SEL_W:0]    idx
    );
        next_bit_t res;
        res.found = 1'b0;
        res.idx   = '0;
        for (int i = CHAN_N - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) begin
                res.found = 1'b1;
                res.idx   = i[SEL_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_scan_next.sv
// -----------------------------------------------------------------------------
// mux_scan_next
//
// Combinational priority finder: reports the lowest enabled channel strictly
// above idx. Driving idx with -1 returns the first enabled channel.
//
// Ports:
//   mask   in  CHAN_N   channel enables
//   idx    in  SEL_W+1  signed start index (exclusive); -1 = search all
//   found  out 1        a qualifying channel exists
//   nxt    out SEL_W    that channel (0 when found=0)
// -----------------------------------------------------------------------------
module mux_scan_next
    import mux_scan_pkg::*;
(
    input  logic        [CHAN_N-1:0] mask,
    input  logic signed [SEL_W:0]    idx,
    output logic                     found,
    output logic        [SEL_W-1:0]  nxt
);

    next_bit_t res;

    always_comb begin
        res   = next_set_bit(mask, idx);
        found = res.found;
        nxt   = res.idx;
    end

endmodule

// File: rtl/mux16_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux16_scan_ctrl
//
// Sequencer for the 16:1 mux benchmark datapath. On an accepted start it
// steps the mux select through the enabled channels, holds each one for
// dwell+1 cycles, samples mux_out on the last cycle of each hold into
// frame[sel], then presents the frame on a valid/ready handshake.
//
// Optional feature (define MUX_SCAN_PARITY_EN): adds output frame_par, the
// XOR of all frame bits, registered and updated as frame_valid rises.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin one scan (only honoured in IDLE)
//   chan_mask    in   16 channel enables, latched at accepted start
//   dwell        in   DWELL_W extra settle cycles per channel, latched at start
//   sel          out  4-bit mux select (registered)
//   mux_dis      out  mux force-inactive (registered), low only while scanning
//   mux_out      in   mux output, sampled synchronously
//   busy         out  high in every state except IDLE
//   frame        out  16-bit assembled frame; masked channels read 0
//   frame_valid  out  frame available
//   frame_ready  in   consumer accepts frame
//   frame_par    out  (MUX_SCAN_PARITY_EN only) parity of frame
// -----------------------------------------------------------------------------
module mux16_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CHAN_N-1:0]  chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               mux_dis,
    input  logic               mux_out,
    output logic               busy,
    output logic [CHAN_N-1:0]  frame,
    output logic               frame_valid,
    input  logic               frame_ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic               frame_par
`endif
);

    state_e               state_q,   state_d;
    logic [SEL_W-1:0]     sel_q,     sel_d;
    logic                 mux_dis_q, mux_dis_d;
    logic [CHAN_N-1:0]    frame_q,   frame_d;
    logic [CHAN_N-1:0]    mask_q,    mask_d;
    logic [DWELL_W-1:0]   dwell_q,   dwell_d;
    logic [DWELL_W-1:0]   cnt_q,     cnt_d;

    logic                 find_found;
    logic [SEL_W-1:0]     find_nxt;
    logic [CHAN_N-1:0]    find_mask;
    logic signed [SEL_W:0] find_idx;

    // In IDLE the search runs on the live mask from -1 so the first channel
    // is known in the same cycle the mask is latched; while scanning it runs
    // on the latched mask from the current select.
    assign find_mask = (state_q == IDLE) ? chan_mask : mask_q;
    assign find_idx  = (state_q == IDLE) ? '1 : $signed({1'b0, sel_q});

    mux_scan_next u_next (
        .mask  (find_mask),
        .idx   (find_idx),
        .found (find_found),
        .nxt   (find_nxt)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        mux_dis_d = mux_dis_q;
        frame_d   = frame_q;
        mask_d    = mask_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = chan_mask;
                    dwell_d = dwell;
                    frame_d = '0;
                    cnt_d   = dwell;
                    if (find_found) begin
                        state_d   = SCAN;
                        sel_d     = find_nxt;
                        mux_dis_d = 1'b0;
                    end else begin
                        state_d   = DONE;
                    end
                end
            end

            SCAN: begin
                if (cnt_q == '0) begin
                    // Last cycle of this channel's hold: the mux has had
                    // dwell+1 cycles to settle, so take the sample now.
                    frame_d[sel_q] = mux_out;
                    if (find_found) begin
                        sel_d = find_nxt;
                        cnt_d = dwell_q;
                    end else begin
                        state_d   = DONE;
                        mux_dis_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end

            DONE: begin
                // start is deliberately not looked at here, even in the
                // handshake cycle; a new scan needs a visit to IDLE.
                if (frame_ready) begin
                    state_d = IDLE;
                    sel_d   = '0;
                end
            end

            default: begin
                state_d   = IDLE;
                sel_d     = '0;
                mux_dis_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            mux_dis_q <= 1'b1;
            frame_q   <= '0;
            mask_q    <= '0;
            dwell_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            mux_dis_q <= mux_dis_d;
            frame_q   <= frame_d;
            mask_q    <= mask_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic frame_par_q, frame_par_d;

    // Parity is taken from the frame value being written as DONE is entered,
    // so it lines up with the first cycle of frame_valid.
    always_comb begin
        frame_par_d = frame_par_q;
        if ((state_d == DONE) && (state_q != DONE)) begin
            frame_par_d = ^frame_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_par_q <= 1'b0;
        end else begin
            frame_par_q <= frame_par_d;
        end
    end

    assign frame_par = frame_par_q;
`endif

    assign sel         = sel_q;
    assign mux_dis     = mux_dis_q;
    assign frame       = frame_q;
    assign busy        = (state_q != IDLE);
    assign frame_valid = (state_q == DONE);

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux16_scan_ctrl
//
// Directed bench for mux16_scan_ctrl. A behavioural 16:1 mux drives mux_out
// from a per-scan channel pattern (forced low while mux_dis is high). A table
// of scans is applied in a loop, followed by hand-written back-pressure and
// mid-scan reset sequences.
// -----------------------------------------------------------------------------
module tb_mux16_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] chan_mask;
    logic [3:0]  dwell;
    logic [3:0]  sel;
    logic        mux_dis;
    logic        mux_out;
    logic        busy;
    logic [15:0] frame;
    logic        frame_valid;
    logic        frame_ready;
`ifdef MUX_SCAN_PARITY_EN
    logic        frame_par;
`endif

    logic [15:0] pattern;

    int n_checks = 0;
    int n_errors = 0;

    mux16_scan_ctrl #(.DWELL_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .chan_mask   (chan_mask),
        .dwell       (dwell),
        .sel         (sel),
        .mux_dis     (mux_dis),
        .mux_out     (mux_out),
        .busy        (busy),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .frame_par   (frame_par)
`endif
    );

    // Behavioural mux: output forced inactive when disabled.
    assign mux_out = mux_dis ? 1'b0 : pattern[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  dwell;
        logic [15:0] pat;
        logic [15:0] exp_frame;
        int          exp_lat;
        logic        exp_par;
    } vec_t;

    // One scan: start at cycle 0, follow the select trace, measure the
    // latency to frame_valid, check the DONE outputs, optionally handshake.
    task automatic run_scan(input vec_t v, input bit ack);
        int chans[16];
        int nset = 0;
        int last = 0;
        int lat  = -1;
        int terr = 0;
        int k;
        for (int i = 0; i < 16; i++) begin
            if (v.mask[i]) begin
                chans[nset] = i;
                nset++;
                last = i;
            end
        end
        @(negedge clk);
        pattern   = v.pat;
        chan_mask = v.mask;
        dwell     = v.dwell;
        start     = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (frame_valid) begin
                lat = c;
                break;
            end
            k = (c - 1) / (int'(v.dwell) + 1);
            if (k >= nset) begin
                terr++;
            end else if ((int'(sel) != chans[k]) || mux_dis) begin
                terr++;
            end
        end
        check("latency", lat, v.exp_lat);
        check("sel_trace_errs", terr, 0);
        check("frame", {16'h0, frame}, {16'h0, v.exp_frame});
        check("done_sel", {28'h0, sel}, last);
        check("done_mux_dis", {31'h0, mux_dis}, 1);
        check("done_busy", {31'h0, busy}, 1);
`ifdef MUX_SCAN_PARITY_EN
        check("frame_par", {31'h0, frame_par}, {31'h0, v.exp_par});
`endif
        if (ack) begin
            frame_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            frame_ready = 1'b0;
            check("ack_busy", {31'h0, busy}, 0);
            check("ack_valid", {31'h0, frame_valid}, 0);
            check("ack_sel", {28'h0, sel}, 0);
            check("ack_frame_held", {16'h0, frame}, {16'h0, v.exp_frame});
        end
    endtask

    vec_t vecs[9];
    vec_t bp_vec;
    vec_t rst_vec;

    initial begin
        int bp_err;
        int wait_cnt;

        //              mask      dw    pattern   frame     lat  par
        vecs[0] = '{16'hFFFF, 4'd0,  16'hA5C3, 16'hA5C3,  17, 1'b0};
        vecs[1] = '{16'h8101, 4'd2,  16'hFFFF, 16'h8101,  10, 1'b1};
        vecs[2] = '{16'h0000, 4'd5,  16'hFFFF, 16'h0000,   1, 1'b0};
        vecs[3] = '{16'h00F0, 4'd1,  16'h5A5A, 16'h0050,   9, 1'b0};
        vecs[4] = '{16'hFFFF, 4'd15, 16'h1234, 16'h1234, 257, 1'b1};
        vecs[5] = '{16'h8000, 4'd0,  16'h8000, 16'h8000,   2, 1'b1};
        vecs[6] = '{16'h0001, 4'd3,  16'h0000, 16'h0000,   5, 1'b0};
        vecs[7] = '{16'h0007, 4'd0,  16'hFFFF, 16'h0007,   4, 1'b1};
        vecs[8] = '{16'h0003, 4'd0,  16'h0003, 16'h0003,   3, 1'b0};
        bp_vec  = '{16'h00FF, 4'd0,  16'h00AA, 16'h00AA,   9, 1'b0};
        rst_vec = '{16'hFFFF, 4'd0,  16'h3C96, 16'h3C96,  17, 1'b0};

        rst_n       = 1'b0;
        start       = 1'b0;
        chan_mask   = 16'h0;
        dwell       = 4'd0;
        frame_ready = 1'b0;
        pattern     = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_sel", {28'h0, sel}, 0);
        check("rst_mux_dis", {31'h0, mux_dis}, 1);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_frame", {16'h0, frame}, 0);
        check("rst_valid", {31'h0, frame_valid}, 0);
`ifdef MUX_SCAN_PARITY_EN
        check("rst_par", {31'h0, frame_par}, 0);
`endif

        for (int i = 0; i < 9; i++) begin
            run_scan(vecs[i], 1'b1);
        end

        // Back-pressure: consumer stalls, start keeps pulsing.
        run_scan(bp_vec, 1'b0);
        bp_err = 0;
        for (int c = 0; c < 20; c++) begin
            start     = c[0];
            chan_mask = 16'hFFFF;
            @(posedge clk);
            @(negedge clk);
            if (!frame_valid || !busy || (frame != 16'h00AA) || (sel != 4'd7) || !mux_dis) begin
                bp_err++;
            end
        end
        check("bp_stable_errs", bp_err, 0);
        frame_ready = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_ready = 1'b0;
        start       = 1'b0;
        check("bp_ack_busy", {31'h0, busy}, 0);
        check("bp_ack_valid", {31'h0, frame_valid}, 0);
        @(posedge clk);
        @(negedge clk);
        check("bp_no_restart", {31'h0, busy}, 0);
        check("bp_frame_held", {16'h0, frame}, 16'h00AA);

        // Reset while channel 5 is being scanned.
        pattern   = 16'hA5C3;
        chan_mask = 16'hFFFF;
        dwell     = 4'd3;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        wait_cnt = 0;
        while ((sel != 4'd5) && (wait_cnt < 200)) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("reach_ch5_timeout", {31'h0, (wait_cnt >= 200)}, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", {28'h0, sel}, 0);
        check("mid_rst_mux_dis", {31'h0, mux_dis}, 1);
        check("mid_rst_busy", {31'h0, busy}, 0);
        check("mid_rst_frame", {16'h0, frame}, 0);
        check("mid_rst_valid", {31'h0, frame_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(rst_vec, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux16_scan_ctrl.md
# mux16_scan_ctrl

Sequencer for the 16:1 multiplexer benchmark datapath. It steps the mux's 4-bit select through a programmable set of enabled channels and holds each select for a programmable dwell so the mux output can settle. It samples the mux output once per channel and assembles a 16-bit frame, which it presents to the consumer on a valid/ready handshake. It sits between a control/host interface and the combinational mux, and is the only driver of the mux's select and enable inputs.

## Interface
- DWELL_W, 4, width of the per-channel dwell count
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one scan; accepted only in IDLE
- chan_mask  in  16  channel enables; bit i=1 means scan channel i; latched at accepted start
- dwell  in  DWELL_W  extra settle cycles per channel; latched at accepted start
- sel  out  4  mux select; registered
- mux_dis  out  1  mux force/disable input; 1 forces the mux output inactive; registered
- mux_out  in  1  mux output, sampled synchronously
- busy  out  1  high in every state except IDLE
- frame  out  16  bit i = sample of channel i; masked channels read 0
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts frame

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: sel=0, mux_dis=1, frame_valid=0. On start=1, latch chan_mask and dwell, and clear the frame register.
  - If the latched mask is nonzero, go to SCAN with sel = lowest set bit.
  - If the latched mask is 0, go directly to DONE.
- SCAN: mux_dis=0. Dwell counter loads the latched dwell on each channel entry and decrements once per cycle.
  - In the cycle where the counter is 0, capture mux_out into frame[sel].
  - In that same cycle, if a higher set mask bit exists, the next cycle's sel = next set bit and the counter reloads. Otherwise go to DONE.
  - Masked channels are never selected.
- DONE: frame_valid=1, mux_dis=1, sel holds its last value. frame stays stable while frame_valid=1.
  - frame_valid & frame_ready → IDLE next cycle. The frame register keeps its value until the next accepted start.
- start is ignored outside IDLE, including in the DONE handshake cycle.
- chan_mask and dwell changes during a scan have no effect.
- Reset, any state: state=IDLE, sel=0, mux_dis=1, busy=0, frame=0, frame_valid=0, counter=0. A scan in progress is abandoned with no partial frame presented.

## Timing
- Let N = popcount(mask) and D = dwell. start is sampled high at cycle 0.
- Cycle 1: sel = first channel.
- Channel k (0-based) is selected for exactly D+1 cycles and sampled at the end of cycle (k+1)(D+1).
- frame_valid rises at cycle N(D+1)+1.
- Total latency from start to frame_valid: N(D+1)+1 cycles. With mask=0, frame_valid rises at cycle 1.
- Back-to-back scans: minimum 2 cycles from handshake to the next frame_valid, since start is accepted in IDLE.
- sel changes only on channel transitions. No glitch cycles, no skipped dwell.

## Configuration
- MUX_SCAN_PARITY_EN defined: adds output frame_par (1 bit) = XOR of the 16 frame bits. It is registered and updated in the same cycle frame_valid rises. Reset value 0.
- Not defined: port absent, no parity logic.

## Structure
- Package mux_scan_pkg holds:
  - CHAN_N=16, SEL_W=4
  - the state enum (IDLE, SCAN, DONE)
  - the function next_set_bit(mask, idx), which returns the lowest set bit above idx and a found flag
- Sub-module mux_scan_next: the combinational priority finder that wraps next_set_bit. It is also used with idx=-1 to find the first channel.

## Test plan
- Full scan: mask=16'hFFFF, dwell=0, mux_out = bit sel of pattern 16'hA5C3 → frame=16'hA5C3, frame_valid at cycle 17.
- Sparse scan: mask=16'h8101, dwell=2 → sel visits 0, 8, 15, each held 3 cycles; unmasked bits read 0; frame_valid at cycle 10.
- Empty mask: mask=0, start → frame=0, frame_valid at cycle 1, sel stays 0, mux_dis stays 1.
- Back-pressure: frame_ready=0 for 20 cycles after frame_valid, with start pulsing meanwhile → frame stable, no new scan; frame_ready=1 → IDLE next cycle.
- Reset mid-scan: rst_n low during SCAN channel 5 → all outputs at reset values immediately; a fresh start produces a correct full frame.
- MUX_SCAN_PARITY_EN: frame=16'h0007 → frame_par=1; frame=16'h0003 → frame_par=0.
